// File: rtl/sha_pkg.sv
// ----------------------------------------------------------------------------
// sha_pkg: shared SHA-256 constants and the sequencer phase codes.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sha_pkg;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00000,
    ST_INIT1    = 5'b01000,
    ST_COMPUTE1 = 5'b10000,
    ST_UPD1     = 5'b01001,
    ST_COMPUTE2 = 5'b10001,
    ST_PREP31   = 5'b01010,
    ST_PREP32   = 5'b01011,
    ST_COMPUTE3 = 5'b10010,
    ST_WRITE    = 5'b00110,
    ST_DONE     = 5'b00111
  } state_t;

  localparam int         HDR_WORDS  = 20;
  localparam logic [6:0] LAST_ROUND = 7'd65;

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Every COMPUTE phase code has bit 4 set.
  function automatic logic is_compute(input state_t s);
    return s[4];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha_k_rom.sv
// ----------------------------------------------------------------------------
// sha_k_rom: combinational SHA-256 round-constant lookup.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sha_k_rom
  import sha_pkg::*;
(
  input  logic [5:0]  idx,
  output logic [31:0] k
);

  assign k = K_TABLE[idx];

endmodule

`default_nettype wire

// File: rtl/bitcoin_ctrl.sv
// ----------------------------------------------------------------------------
// bitcoin_ctrl: lock-step sequencer for the shared SHA-256 compression array.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bitcoin_ctrl
  import sha_pkg::*;
#(
  parameter int NUM_NONCES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [15:0]              message_addr,
  input  logic [15:0]              output_addr,
  input  logic [32*NUM_NONCES-1:0] hout_bus,
  output logic                     done,
  output logic [4:0]               state,
  output logic [6:0]               t,
  output logic [31:0]              k1,
  output logic [15:0]              mem_addr,
  output logic                     mem_we,
  output logic [31:0]              mem_write_data
);

  localparam int               IDX_W    = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NONCES - 1);

  state_t           cur_state, nxt_state;
  logic [6:0]       nxt_t;
  logic [IDX_W-1:0] idx, nxt_idx;
  logic [15:0]      nxt_addr;
  logic [31:0]      nxt_data;
  logic [31:0]      rom_k;
  logic [31:0]      hout_words [NUM_NONCES];

  for (genvar g = 0; g < NUM_NONCES; g++) begin : g_hout
    assign hout_words[g] = hout_bus[32*g +: 32];
  end

  sha_k_rom u_k_rom (
    .idx (t[5:0]),
    .k   (rom_k)
  );

  assign state = cur_state;
  assign k1    = (is_compute(cur_state) && t < 7'd64) ? rom_k : 32'd0;

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      ST_IDLE:     if (start) nxt_state = ST_INIT1;
      ST_INIT1:    nxt_state = ST_COMPUTE1;
      ST_COMPUTE1: if (t == LAST_ROUND) nxt_state = ST_UPD1;
      ST_UPD1:     nxt_state = ST_COMPUTE2;
      ST_COMPUTE2: if (t == LAST_ROUND) nxt_state = ST_PREP31;
      ST_PREP31:   nxt_state = ST_PREP32;
      ST_PREP32:   nxt_state = ST_COMPUTE3;
      ST_COMPUTE3: if (t == LAST_ROUND) nxt_state = ST_WRITE;
      ST_WRITE:    if (idx == LAST_IDX) nxt_state = ST_DONE;
      ST_DONE:     nxt_state = ST_IDLE;
      default:     nxt_state = ST_IDLE;
    endcase

    nxt_t   = (is_compute(nxt_state) && nxt_state == cur_state) ? t + 7'd1 : 7'd0;
    nxt_idx = (cur_state == ST_WRITE && nxt_state == ST_WRITE) ? idx + IDX_W'(1) : '0;

    // Outputs are registered, so addresses are derived from the upcoming phase.
    nxt_addr = mem_addr;
    nxt_data = mem_write_data;
    case (nxt_state)
      ST_INIT1:    nxt_addr = message_addr;
      ST_COMPUTE1: if (nxt_t < 7'd15) nxt_addr = message_addr + {9'd0, nxt_t} + 16'd1;
      ST_UPD1:     nxt_addr = message_addr + 16'd16;
      ST_COMPUTE2: if (nxt_t == 7'd0) nxt_addr = message_addr + 16'd17;
      ST_WRITE: begin
        nxt_addr = output_addr + {{(16-IDX_W){1'b0}}, nxt_idx};
        nxt_data = hout_words[nxt_idx];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state      <= ST_IDLE;
      t              <= 7'd0;
      idx            <= '0;
      mem_addr       <= 16'd0;
      mem_we         <= 1'b0;
      mem_write_data <= 32'd0;
      done           <= 1'b0;
    end else begin
      cur_state      <= nxt_state;
      t              <= nxt_t;
      idx            <= nxt_idx;
      mem_addr       <= nxt_addr;
      mem_we         <= (nxt_state == ST_WRITE);
      mem_write_data <= nxt_data;
      done           <= (nxt_state == ST_DONE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bitcoin_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bitcoin_ctrl: cycle-schedule reference model checks for bitcoin_ctrl.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bitcoin_ctrl;

  localparam int N   = 16;
  localparam int JOB = 204 + N;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [15:0]    message_addr = 16'd0;
  logic [15:0]    output_addr = 16'd0;
  logic [32*N-1:0] hout_bus = '0;
  logic           done;
  logic [4:0]     state;
  logic [6:0]     t;
  logic [31:0]    k1;
  logic [15:0]    mem_addr;
  logic           mem_we;
  logic [31:0]    mem_write_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] hw [N];
  logic [4:0]  e_state;
  int          e_t;
  logic [31:0] e_k1;
  logic [15:0] e_addr;
  logic        e_we, e_done;
  logic [31:0] e_data;

  logic [31:0] kref [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  bitcoin_ctrl #(.NUM_NONCES(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .message_addr   (message_addr),
    .output_addr    (output_addr),
    .hout_bus       (hout_bus),
    .done           (done),
    .state          (state),
    .t              (t),
    .k1             (k1),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_write_data (mem_write_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all(input int cyc);
    chk("state", cyc, {27'd0, state}, {27'd0, e_state});
    chk("t", cyc, {25'd0, t}, 32'(e_t));
    chk("k1", cyc, k1, e_k1);
    chk("mem_addr", cyc, {16'd0, mem_addr}, {16'd0, e_addr});
    chk("mem_we", cyc, {31'd0, mem_we}, {31'd0, e_we});
    chk("mem_write_data", cyc, mem_write_data, e_data);
    chk("done", cyc, {31'd0, done}, {31'd0, e_done});
  endtask

  task automatic model_reset();
    e_state = 5'b00000; e_t = 0; e_k1 = 0; e_addr = 0;
    e_we = 0; e_done = 0; e_data = 0;
  endtask

  // Expected outputs for cycle cj (1..JOB) of a job, from the phase schedule.
  task automatic model_cycle(input int cj, input logic [15:0] msg, input logic [15:0] out);
    bit comp;
    comp = 0; e_t = 0; e_we = 0; e_done = 0; e_state = 5'b00000;
    if (cj == 1) begin
      e_state = 5'b01000; e_addr = msg;
    end else if (cj <= 67) begin
      e_state = 5'b10000; comp = 1; e_t = cj - 2;
      if (e_t < 15) e_addr = 16'(int'(msg) + e_t + 1);
    end else if (cj == 68) begin
      e_state = 5'b01001; e_addr = 16'(int'(msg) + 16);
    end else if (cj <= 134) begin
      e_state = 5'b10001; comp = 1; e_t = cj - 69;
      if (cj == 69) e_addr = 16'(int'(msg) + 17);
    end else if (cj == 135) begin
      e_state = 5'b01010;
    end else if (cj == 136) begin
      e_state = 5'b01011;
    end else if (cj <= 202) begin
      e_state = 5'b10010; comp = 1; e_t = cj - 137;
    end else if (cj <= 202 + N) begin
      e_state = 5'b00110; e_we = 1;
      e_addr = 16'(int'(out) + cj - 203);
      e_data = hw[cj - 203];
    end else if (cj == 203 + N) begin
      e_state = 5'b00111; e_done = 1;
    end
    e_k1 = (comp && e_t < 64) ? kref[e_t] : 32'd0;
  endtask

  task automatic run_job(input logic [15:0] msg, input logic [15:0] out, input bit hold,
                         input int pulse_at, input int reset_at);
    int last, cj;
    for (int i = 0; i < N; i++) begin
      hw[i] = $urandom();
      hout_bus[32*i +: 32] = hw[i];
    end
    message_addr = msg;
    output_addr  = out;
    start        = 1'b1;
    last = hold ? 2 * JOB : JOB;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      start = hold ? (c < last) : (c == pulse_at);
      cj = ((c - 1) % JOB) + 1;
      model_cycle(cj, msg, out);
      check_all(c);
      if (c == reset_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        check_all(c + 1);
        for (int k = 2; k <= 4; k++) begin
          @(posedge clk); #1;
          check_all(c + k);
        end
        return;
      end
    end
  endtask

  initial begin
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_all(c);
    end
    reset = 1'b0;
    for (int c = 3; c < 8; c++) begin
      @(posedge clk); #1;
      check_all(c);
    end

    run_job(16'h0000, 16'h0100, 1'b0, 0, 0);
    run_job(16'h0040, 16'(($urandom())), 1'b0, 30, 0);
    run_job(16'hFFFE, 16'hFFF8, 1'b0, 0, 0);
    run_job(16'(($urandom())), 16'(($urandom())), 1'b0, 0, 100);
    run_job(16'h1234, 16'h0200, 1'b0, 0, 0);
    run_job(16'(($urandom())), 16'(($urandom())), 1'b1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
